// File: rtl/hit_keypad_scanner.sv
// 4x4 active-low key matrix scanner with frame-based debounce and one-cycle press pulses.
// Build option: define MULTI_KEY_EN to let Hit_point carry several simultaneous presses.
module hit_keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        Clk,
  input  logic        Set,
  input  logic        Enable,
  input  logic [3:0]  Row_n,
  output logic [3:0]  Col_n,
  output logic [15:0] Hit_point,
  output logic [15:0] Key_down,
  output logic        Frame_tick
);

  localparam int unsigned     DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB      = 4'(DEBOUNCE);

  logic [3:0]       sync1, sync2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [15:0]      raw, raw_next, prev;
  logic [3:0]       stable_cnt;
  logic [15:0]      key_down_d, rise, hit_next;
  logic             sample, frame_end;

  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (col == 2'd3);

  // Completed frame including the column being sampled this cycle
  always_comb begin
    raw_next = raw;
    for (int unsigned r = 0; r < 4; r++) begin
      raw_next[{r[1:0], col}] = ~sync2[r];
    end
  end

  assign rise = Key_down & ~key_down_d;

`ifdef MULTI_KEY_EN
  assign hit_next = rise;
`else
  // Isolate the lowest set bit; other simultaneous presses are dropped
  assign hit_next = rise & (~rise + 16'd1);
`endif

  always_ff @(posedge Clk or negedge Set) begin
    if (!Set) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= Row_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge Clk or negedge Set) begin
    if (!Set) begin
      div   <= '0;
      col   <= '0;
      Col_n <= 4'b1110;
      raw   <= '0;
    end else if (sample) begin
      div   <= '0;
      col   <= col + 2'd1;
      Col_n <= ~(4'b0001 << (col + 2'd1));
      raw   <= raw_next;
    end else begin
      div   <= div + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Set) begin
    if (!Set) begin
      prev       <= '0;
      stable_cnt <= '0;
      Frame_tick <= 1'b0;
    end else begin
      Frame_tick <= frame_end;
      if (frame_end) begin
        if (raw_next == prev) begin
          if (stable_cnt != DEB) stable_cnt <= stable_cnt + 4'd1;
        end else begin
          stable_cnt <= 4'd1;
          prev       <= raw_next;
        end
      end
    end
  end

  // Key_down follows raw one cycle after a frame end that left the count saturated
  always_ff @(posedge Clk or negedge Set) begin
    if (!Set) begin
      Key_down   <= '0;
      key_down_d <= '0;
      Hit_point  <= '0;
    end else begin
      if (Frame_tick && (stable_cnt == DEB)) Key_down <= raw;
      key_down_d <= Key_down;
      Hit_point  <= hit_next & {16{Enable}};
    end
  end

endmodule
